// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the serial frame transmitter family.
//   tx_state_t : frame FSM states
//   SYNC_1010  : default sync marker
//   max()      : integer maximum, used for counter sizing
package seq_fsm_pkg;

   // Prefixed names keep the GAP state clear of the GAP parameter of the
   // modules that import this package.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MARK = 2'd1,
      ST_DATA = 2'd2,
      ST_GAP  = 2'd3
   } tx_state_t;

   localparam logic [3:0] SYNC_1010 = 4'b1010;

   function automatic int max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first.
//   clk, rst : clock, asynchronous active-high reset
//   load_i   : capture data_i (has priority over shift_i)
//   shift_i  : shift left by one, zero fill
//   data_i   : parallel word
//   msb_o    : current most significant bit
module piso_shift_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] data_i,
   output logic         msb_o
);

   logic [W-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load_i)
         sr_d = data_i;
      else if (shift_i)
         sr_d = sr_q << 1;   // stays W wide, so W==1 simply clears
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sr_q <= '0;
      else     sr_q <= sr_d;
   end

   assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync marker, payload MSB-first, idle gap.
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : payload word, accepted on in_valid && in_ready
//   in_valid   : payload offered
//   in_ready   : high in IDLE only (low while in reset)
//   tx_out     : serial bit, IDLE_BIT outside marker/payload
//   tx_valid   : tx_out carries a marker or payload bit
//   busy       : frame in progress
//   frame_done : one-cycle pulse in the cycle after the last payload bit
// All outputs decode registered state only.
module seq_frame_tx
   import seq_fsm_pkg::*;
#(
   parameter int                    DATA_W   = 8,
   parameter int                    MARKER_W = 4,
   parameter logic [MARKER_W-1:0]   MARKER   = MARKER_W'(SYNC_1010),
   parameter int                    GAP      = 2,
   parameter logic                  IDLE_BIT = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_out,
   output logic              tx_valid,
   output logic              busy,
   output logic              frame_done
);

   localparam int CNT_W = $clog2(max(max(DATA_W, MARKER_W), max(GAP, 1)) + 1);

   tx_state_t          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               in_ready_q;
   logic               frame_done_q, frame_done_d;
   logic               sr_load, sr_shift, sr_msb;
   logic               accept;
   logic [MARKER_W-1:0] mark_sh;

   // in_ready_q tracks "next state is IDLE", so it equals (state_q == IDLE)
   // except that it stays low through reset and the release cycle.
   assign accept = in_valid && in_ready_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      sr_load      = 1'b0;
      sr_shift     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               sr_load = 1'b1;
               cnt_d   = CNT_W'(MARKER_W - 1);
               state_d = ST_MARK;
            end
         end
         ST_MARK: begin
            if (cnt_q == '0) begin
               cnt_d   = CNT_W'(DATA_W - 1);
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DATA: begin
            sr_shift = 1'b1;
            if (cnt_q == '0) begin
               frame_done_d = 1'b1;
               if (GAP > 0) begin
                  cnt_d   = CNT_W'(GAP - 1);
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         in_ready_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         in_ready_q   <= (state_d == ST_IDLE);
         frame_done_q <= frame_done_d;
      end
   end

   piso_shift_reg #(.W(DATA_W)) u_sr (
      .clk     (clk),
      .rst     (rst),
      .load_i  (sr_load),
      .shift_i (sr_shift),
      .data_i  (in_data),
      .msb_o   (sr_msb)
   );

   // Marker bit cnt selected by shifting, avoiding an index-width mismatch
   // when the counter is wider than the marker needs.
   assign mark_sh = MARKER >> cnt_q;

   always_comb begin
      tx_out = IDLE_BIT;
      case (state_q)
         ST_MARK: tx_out = mark_sh[0];
         ST_DATA: tx_out = sr_msb;
         default: tx_out = IDLE_BIT;
      endcase
   end

   assign tx_valid   = (state_q == ST_MARK) || (state_q == ST_DATA);
   assign busy       = (state_q != ST_IDLE);
   assign in_ready   = in_ready_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench: default instance plus GAP=0, DATA_W=1, MARKER_W=1 variants.
module tb_seq_frame_tx;

   logic       clk, rst;
   logic       iv[4], ir[4], to[4], tv[4], bz[4], fd[4];
   logic [7:0] d0, d1, d3;
   logic [0:0] d2;

   int         cyc;
   logic [4:0] lg[4][4096];   // {in_ready, busy, frame_done, tx_valid, tx_out}
   int         acc_n[4];
   int         acc_c[4][16];
   int         n_chk, n_pass;

   seq_frame_tx u0 (.clk(clk), .rst(rst), .in_data(d0), .in_valid(iv[0]), .in_ready(ir[0]),
                    .tx_out(to[0]), .tx_valid(tv[0]), .busy(bz[0]), .frame_done(fd[0]));
   seq_frame_tx #(.GAP(0)) u1 (.clk(clk), .rst(rst), .in_data(d1), .in_valid(iv[1]), .in_ready(ir[1]),
                    .tx_out(to[1]), .tx_valid(tv[1]), .busy(bz[1]), .frame_done(fd[1]));
   seq_frame_tx #(.DATA_W(1)) u2 (.clk(clk), .rst(rst), .in_data(d2), .in_valid(iv[2]), .in_ready(ir[2]),
                    .tx_out(to[2]), .tx_valid(tv[2]), .busy(bz[2]), .frame_done(fd[2]));
   seq_frame_tx #(.MARKER_W(1), .MARKER(1'b1)) u3 (.clk(clk), .rst(rst), .in_data(d3), .in_valid(iv[3]),
                    .in_ready(ir[3]), .tx_out(to[3]), .tx_valid(tv[3]), .busy(bz[3]), .frame_done(fd[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle log sampled mid-cycle; acceptance recorded as the cycle whose
   // closing edge takes the word (that cycle is "cycle 0" of the frame).
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (cyc < 4096) lg[i][cyc] <= {ir[i], bz[i], fd[i], tv[i], to[i]};
         if (iv[i] && ir[i] && !rst && acc_n[i] < 16) begin
            acc_c[i][acc_n[i]] <= cyc;
            acc_n[i] <= acc_n[i] + 1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic wait_acc(input int d, input int tgt, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (acc_n[d] >= tgt) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      #2;
      n_chk++; if (to[0] !== 1'b0) $display("FAIL rst_tx_out got %b want 0", to[0]); else n_pass++;
      n_chk++; if (tv[0] !== 1'b0) $display("FAIL rst_tx_valid got %b want 0", tv[0]); else n_pass++;
      n_chk++; if (bz[0] !== 1'b0) $display("FAIL rst_busy got %b want 0", bz[0]); else n_pass++;
      n_chk++; if (fd[0] !== 1'b0) $display("FAIL rst_frame_done got %b want 0", fd[0]); else n_pass++;
      n_chk++; if (ir[0] !== 1'b0) $display("FAIL rst_in_ready got %b want 0", ir[0]); else n_pass++;
      iv[0] = 1'b1; d0 = 8'h55;           // offered across the release cycle
      @(negedge clk); rst = 1'b0; #1;
      n_chk++; if (ir[0] !== 1'b0) $display("FAIL rel_in_ready_early got %b want 0", ir[0]); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (ir[0] !== 1'b1) $display("FAIL rel_in_ready got %b want 1", ir[0]); else n_pass++;
      n_chk++; if (bz[0] !== 1'b0) $display("FAIL rel_no_accept_busy got %b want 0", bz[0]); else n_pass++;
      iv[0] = 1'b0;
      @(negedge clk); #1;
      n_chk++; if (bz[0] !== 1'b0 || acc_n[0] != 0) $display("FAIL rel_no_accept got busy=%b acc=%0d want 0/0", bz[0], acc_n[0]); else n_pass++;
   endtask

   task automatic test_single();
      logic [11:0] e; int c, n; bit ok;
      e = {4'b1010, 8'hA5};
      @(posedge clk); #1;
      n = acc_n[0]; d0 = 8'hA5; iv[0] = 1'b1;
      wait_acc(0, n + 1, ok);
      n_chk++; if (!ok) $display("FAIL single_accept timeout got no acceptance want one"); else n_pass++;
      c = acc_c[0][n];
      @(posedge clk); #1; iv[0] = 1'b0;
      repeat (16) @(negedge clk); #1;
      for (int k = 1; k <= 15; k++) begin
         n_chk++; if (lg[0][c+k][0] !== ((k <= 12) ? e[12-k] : 1'b0))
            $display("FAIL single_tx_out cyc%0d got %b want %b", k, lg[0][c+k][0], (k <= 12) ? e[12-k] : 1'b0); else n_pass++;
         n_chk++; if (lg[0][c+k][1] !== (k <= 12))
            $display("FAIL single_tx_valid cyc%0d got %b want %b", k, lg[0][c+k][1], k <= 12); else n_pass++;
         n_chk++; if (lg[0][c+k][2] !== (k == 13))
            $display("FAIL single_frame_done cyc%0d got %b want %b", k, lg[0][c+k][2], k == 13); else n_pass++;
         n_chk++; if (lg[0][c+k][4] !== (k == 15))
            $display("FAIL single_in_ready cyc%0d got %b want %b", k, lg[0][c+k][4], k == 15); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] e1, e2; int c1, c2, n; bit ok;
      e1 = {4'b1010, 8'hFF}; e2 = {4'b1010, 8'h00};
      @(posedge clk); #1;
      n = acc_n[0]; d0 = 8'hFF; iv[0] = 1'b1;
      wait_acc(0, n + 1, ok);
      c1 = acc_c[0][n];
      @(posedge clk); #1; d0 = 8'h00;
      wait_acc(0, n + 2, ok);
      n_chk++; if (!ok) $display("FAIL b2b_accept timeout got %0d acceptances want 2", acc_n[0] - n); else n_pass++;
      c2 = acc_c[0][n+1];
      @(posedge clk); #1; iv[0] = 1'b0;
      n_chk++; if (c2 - c1 != 15) $display("FAIL b2b_period got %0d want 15", c2 - c1); else n_pass++;
      repeat (16) @(negedge clk); #1;
      for (int k = 1; k <= 12; k++) begin
         n_chk++; if (lg[0][c1+k][1:0] !== {1'b1, e1[12-k]})
            $display("FAIL b2b_frame1 cyc%0d got %b want %b", k, lg[0][c1+k][1:0], {1'b1, e1[12-k]}); else n_pass++;
         n_chk++; if (lg[0][c2+k][1:0] !== {1'b1, e2[12-k]})
            $display("FAIL b2b_frame2 cyc%0d got %b want %b", k, lg[0][c2+k][1:0], {1'b1, e2[12-k]}); else n_pass++;
      end
   endtask

   task automatic test_payload_hold();
      logic [7:0] e; int c, n; bit ok;
      e = 8'h3C;
      @(posedge clk); #1;
      n = acc_n[0]; d0 = 8'h3C; iv[0] = 1'b1;
      wait_acc(0, n + 1, ok);
      n_chk++; if (!ok) $display("FAIL hold_accept timeout got no acceptance want one"); else n_pass++;
      c = acc_c[0][n];
      @(posedge clk); #1; iv[0] = 1'b0;
      @(posedge clk); #1; d0 = 8'hFF;     // during MARK
      repeat (14) @(negedge clk); #1;
      for (int k = 5; k <= 12; k++) begin
         n_chk++; if (lg[0][c+k][0] !== e[12-k])
            $display("FAIL hold_payload cyc%0d got %b want %b", k, lg[0][c+k][0], e[12-k]); else n_pass++;
      end
      n_chk++; if (lg[0][c+13][2] !== 1'b1) $display("FAIL hold_frame_done got %b want 1", lg[0][c+13][2]); else n_pass++;
   endtask

   task automatic test_reset_mid_data();
      logic [11:0] e; int c, n; bit ok;
      @(posedge clk); #1;
      n = acc_n[0]; d0 = 8'hF0; iv[0] = 1'b1;
      wait_acc(0, n + 1, ok);
      @(posedge clk); #1; iv[0] = 1'b0;
      repeat (7) @(negedge clk);          // cycle 7: third payload bit
      n_chk++; if (!ok || tv[0] !== 1'b1 || to[0] !== 1'b1)
         $display("FAIL rmd_pre got ok=%b valid=%b bit=%b want 1/1/1", ok, tv[0], to[0]); else n_pass++;
      rst = 1'b1; #1;
      n_chk++; if ({to[0], tv[0], bz[0], fd[0], ir[0]} !== 5'b00000)
         $display("FAIL rmd_abort got %b want 00000", {to[0], tv[0], bz[0], fd[0], ir[0]}); else n_pass++;
      @(negedge clk); rst = 1'b0; #1;
      n_chk++; if (ir[0] !== 1'b0) $display("FAIL rmd_in_ready_early got %b want 0", ir[0]); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (ir[0] !== 1'b1 || bz[0] !== 1'b0)
         $display("FAIL rmd_idle got ready=%b busy=%b want 1/0", ir[0], bz[0]); else n_pass++;
      e = {4'b1010, 8'h81};
      n = acc_n[0]; d0 = 8'h81; iv[0] = 1'b1;
      wait_acc(0, n + 1, ok);
      n_chk++; if (!ok) $display("FAIL rmd_accept timeout got no acceptance want one"); else n_pass++;
      c = acc_c[0][n];
      @(posedge clk); #1; iv[0] = 1'b0;
      repeat (16) @(negedge clk); #1;
      for (int k = 1; k <= 14; k++) begin
         n_chk++; if (lg[0][c+k][2:0] !== {k == 13, k <= 12, (k <= 12) ? e[12-k] : 1'b0})
            $display("FAIL rmd_frame cyc%0d got %b want %b", k, lg[0][c+k][2:0],
                     {k == 13, k <= 12, (k <= 12) ? e[12-k] : 1'b0}); else n_pass++;
      end
   endtask

   task automatic test_sweep();
      logic [11:0] e; logic [8:0] e3; int c1, c2, n; bit ok;
      // GAP = 0, held valid
      e = {4'b1010, 8'hC3};
      @(posedge clk); #1;
      n = acc_n[1]; d1 = 8'hC3; iv[1] = 1'b1;
      wait_acc(1, n + 1, ok);
      c1 = acc_c[1][n];
      @(posedge clk); #1;
      wait_acc(1, n + 2, ok);
      n_chk++; if (!ok) $display("FAIL gap0_accept timeout got %0d want 2", acc_n[1] - n); else n_pass++;
      c2 = acc_c[1][n+1];
      @(posedge clk); #1; iv[1] = 1'b0;
      n_chk++; if (c2 - c1 != 13) $display("FAIL gap0_period got %0d want 13", c2 - c1); else n_pass++;
      repeat (14) @(negedge clk); #1;
      for (int k = 1; k <= 12; k++) begin
         n_chk++; if (lg[1][c1+k][1:0] !== {1'b1, e[12-k]})
            $display("FAIL gap0_bits cyc%0d got %b want %b", k, lg[1][c1+k][1:0], {1'b1, e[12-k]}); else n_pass++;
      end
      n_chk++; if (lg[1][c1+13][4:1] !== 4'b1010)
         $display("FAIL gap0_done_idle got %b want 1010", lg[1][c1+13][4:1]); else n_pass++;
      n_chk++; if (lg[1][c1+12][2] !== 1'b0) $display("FAIL gap0_done_early got %b want 0", lg[1][c1+12][2]); else n_pass++;

      // DATA_W = 1
      @(posedge clk); #1;
      n = acc_n[2]; d2 = 1'b1; iv[2] = 1'b1;
      wait_acc(2, n + 1, ok);
      n_chk++; if (!ok) $display("FAIL dw1_accept timeout got none want one"); else n_pass++;
      c1 = acc_c[2][n];
      @(posedge clk); #1; iv[2] = 1'b0;
      repeat (10) @(negedge clk); #1;
      for (int k = 1; k <= 8; k++) begin
         n_chk++; if (lg[2][c1+k] !== {k == 8, k <= 7, k == 6, k <= 5, (k <= 5) ? ((k % 2) == 1) : 1'b0})
            $display("FAIL dw1_frame cyc%0d got %b want %b", k, lg[2][c1+k],
                     {k == 8, k <= 7, k == 6, k <= 5, (k <= 5) ? ((k % 2) == 1) : 1'b0}); else n_pass++;
      end

      // MARKER_W = 1, MARKER = 1
      e3 = {1'b1, 8'h5A};
      @(posedge clk); #1;
      n = acc_n[3]; d3 = 8'h5A; iv[3] = 1'b1;
      wait_acc(3, n + 1, ok);
      n_chk++; if (!ok) $display("FAIL mw1_accept timeout got none want one"); else n_pass++;
      c1 = acc_c[3][n];
      @(posedge clk); #1; iv[3] = 1'b0;
      repeat (14) @(negedge clk); #1;
      for (int k = 1; k <= 12; k++) begin
         n_chk++; if (lg[3][c1+k] !== {k == 12, k <= 11, k == 10, k <= 9, (k <= 9) ? e3[9-k] : 1'b0})
            $display("FAIL mw1_frame cyc%0d got %b want %b", k, lg[3][c1+k],
                     {k == 12, k <= 11, k == 10, k <= 9, (k <= 9) ? e3[9-k] : 1'b0}); else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1;
      n_chk = 0; n_pass = 0; cyc = 0;
      d0 = '0; d1 = '0; d2 = '0; d3 = '0;
      for (int i = 0; i < 4; i++) begin iv[i] = 1'b0; acc_n[i] = 0; end
      test_reset();
      test_single();
      test_back_to_back();
      test_payload_hold();
      test_reset_mid_data();
      test_sweep();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
